draw_bg_rom_reader: RTL and testbench
=====================================

// Module: draw_bg_rom_reader
// PURPOSE
//  Read-side client of the background image ROM (1-cycle registered read, 12-bit RGB).
//  Takes the VGA timing stream and generates ROM addresses from hcount/vcount.
//  Adds a per-frame horizontal scroll offset and a transparent colour key.
//  Delays all timing signals to match the ROM latency. Sits between the timing generator and later draw stages.
// PARAMETERS
//  IMG_W        1024    image width in pixels (window and address stride)
//  IMG_H        768     image height in pixels
//  ADDR_W       20      ROM address width; IMG_W*IMG_H must be <= 2**ADDR_W
//  SCROLL_STEP  1       pixels added to scroll offset per frame when scroll_en=1 (< IMG_W)
//  KEY_COLOR    12'hF0F ROM colour treated as transparent
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous reset, active low
//  hcount_in  in   11     horizontal pixel counter
//  vcount_in  in   11     vertical line counter
//  hsync_in   in   1      horizontal sync
//  vsync_in   in   1      vertical sync
//  hblnk_in   in   1      horizontal blanking
//  vblnk_in   in   1      vertical blanking
//  rgb_in     in   12     upstream pixel colour
//  scroll_en  in   1      enable per-frame scroll increment
//  rom_addr   out  ADDR_W address to image ROM, registered
//  rom_rgb    in   12     ROM data, valid 1 cycle after rom_addr
//  hcount_out, vcount_out  out 11  timing counters delayed 3 cycles
//  hsync_out, vsync_out, hblnk_out, vblnk_out  out 1  delayed 3 cycles
//  rgb_out    out  12     composed pixel, registered
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, scroll_x=0, all pipeline registers 0.
//  Pipeline: inputs in cycle c -> rom_addr valid c+1 -> rom_rgb valid c+2 -> all outputs valid c+3.
//  Total latency 3 cycles; every timing output is the input delayed by exactly 3 cycles.
//  Stage 1 (registered): in_win = !hblnk_in && !vblnk_in && hcount_in<IMG_W && vcount_in<IMG_H.
//   x_img = (hcount_in + scroll_x) mod IMG_W, computed with 1 extra bit and a single conditional subtract.
//   rom_addr = vcount_in*IMG_W + x_img when in_win; otherwise rom_addr holds its previous value.
//  Stage 2: in_win, rgb_in and timing are delayed one more cycle while the ROM reads.
//  Stage 3 (registered): rgb_out = 0 if hblnk or vblnk (delayed);
//   else rgb_in(delayed) if !in_win or rom_rgb==KEY_COLOR; else rom_rgb.
//  Scroll counter: vblnk_in rising edge (0->1, registered-edge detect) and scroll_en=1 -> scroll_x += SCROLL_STEP.
//   Wrap: if sum >= IMG_W, subtract IMG_W; scroll_x is always in [0, IMG_W-1].
//   scroll_x is constant during the active frame; no mid-frame tearing.
//   scroll_en=0 on that edge -> scroll_x holds its value.
//   vblnk held high for many cycles -> exactly one increment per rising edge.
//  Reset mid-frame: pipeline clears; first valid output is 3 cycles after release; scroll_x restarts at 0.
//  No backpressure: the block consumes one pixel per clock unconditionally.
// TESTING
//  1 Assert rst_n=0 mid-stream -> all outputs 0 immediately (async), scroll_x=0.
//  2 hcount=5, vcount=3, active, scroll 0 -> rom_addr=3077 at c+1; rgb_out=ROM[3077] at c+3; hsync_out=hsync_in(c).
//  3 hblnk_in=1, rgb_in=12'hABC -> rgb_out=0 at c+3; rom_addr unchanged from previous active pixel.
//  4 IMG_W=48, IMG_H=64, hcount=100, rgb_in=12'h123 -> rgb_out=12'h123 (outside window).
//  5 SCROLL_STEP=4, scroll_en=1, 3 vblnk rising edges -> scroll_x=12; then hcount=1020, vcount=0 -> rom_addr=8.
//  6 ROM model returns KEY_COLOR at an active pixel, rgb_in=12'h0F0 -> rgb_out=12'h0F0; any other ROM value -> that value.

Source files
------------

// File: rtl/draw_bg_rom_reader_if.sv
//------------------------------------------------------------------------------
// draw_bg_rom_reader_if : VGA timing in/out, pixel colour and image ROM port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface draw_bg_rom_reader_if #(
  parameter int ADDR_W = 20
);
  logic [10:0]       hcount_in;
  logic [10:0]       vcount_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              hblnk_in;
  logic              vblnk_in;
  logic [11:0]       rgb_in;
  logic              scroll_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_rgb;
  logic [10:0]       hcount_out;
  logic [10:0]       vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic [11:0]       rgb_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, scroll_en, rom_rgb,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, scroll_en, rom_rgb,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out
  );
endinterface

`default_nettype wire

// File: rtl/draw_bg_rom_reader.sv
//------------------------------------------------------------------------------
// draw_bg_rom_reader : scrolled background ROM lookup with colour key, 3-cycle pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module draw_bg_rom_reader #(
  parameter int          IMG_W       = 1024,
  parameter int          IMG_H       = 768,
  parameter int          ADDR_W      = 20,
  parameter int          SCROLL_STEP = 1,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  draw_bg_rom_reader_if.slave bus
);

  localparam int SW = $clog2(IMG_W);
  localparam int XW = SW + 1;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } timing_t;

  timing_t           tm_in, tm1, tm2, tm3;
  logic              in_win, in_win1, in_win2;
  logic [11:0]       rgb1, rgb2, rgb3;
  logic [ADDR_W-1:0] rom_addr_q, addr_next;
  logic [XW-1:0]     x_sum, x_img;
  logic [SW-1:0]     scroll_x;
  logic [SW:0]       scroll_sum;
  logic [SW-1:0]     scroll_next;
  logic              vblnk_d, vblnk_rise;

  assign tm_in = '{hc: bus.hcount_in, vc: bus.vcount_in, hs: bus.hsync_in,
                   vs: bus.vsync_in, hb: bus.hblnk_in, vb: bus.vblnk_in};

  assign in_win = !bus.hblnk_in && !bus.vblnk_in &&
                  (32'(bus.hcount_in) < IMG_W) && (32'(bus.vcount_in) < IMG_H);

  // hcount fits in XW-1 bits whenever in_win, so one subtract wraps the sum
  assign x_sum     = XW'(bus.hcount_in) + {1'b0, scroll_x};
  assign x_img     = (x_sum >= XW'(IMG_W)) ? x_sum - XW'(IMG_W) : x_sum;
  assign addr_next = ADDR_W'(bus.vcount_in) * ADDR_W'(IMG_W) + ADDR_W'(x_img);

  assign vblnk_rise  = bus.vblnk_in && !vblnk_d;
  assign scroll_sum  = {1'b0, scroll_x} + (SW+1)'(SCROLL_STEP);
  assign scroll_next = (scroll_sum >= (SW+1)'(IMG_W)) ?
                       SW'(scroll_sum - (SW+1)'(IMG_W)) : SW'(scroll_sum);

  // Scroll only moves on the vblank rising edge, so an active frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d  <= 1'b0;
      scroll_x <= '0;
    end else begin
      vblnk_d <= bus.vblnk_in;
      if (vblnk_rise && bus.scroll_en)
        scroll_x <= scroll_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm1        <= '0;
      in_win1    <= 1'b0;
      rgb1       <= '0;
      rom_addr_q <= '0;
    end else begin
      tm1     <= tm_in;
      in_win1 <= in_win;
      rgb1    <= bus.rgb_in;
      if (in_win)
        rom_addr_q <= addr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm2     <= '0;
      in_win2 <= 1'b0;
      rgb2    <= '0;
    end else begin
      tm2     <= tm1;
      in_win2 <= in_win1;
      rgb2    <= rgb1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm3  <= '0;
      rgb3 <= '0;
    end else begin
      tm3 <= tm2;
      if (tm2.hb || tm2.vb)
        rgb3 <= '0;
      else if (!in_win2 || bus.rom_rgb == KEY_COLOR)
        rgb3 <= rgb2;
      else
        rgb3 <= bus.rom_rgb;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.hcount_out = tm3.hc;
  assign bus.vcount_out = tm3.vc;
  assign bus.hsync_out  = tm3.hs;
  assign bus.vsync_out  = tm3.vs;
  assign bus.hblnk_out  = tm3.hb;
  assign bus.vblnk_out  = tm3.vb;
  assign bus.rgb_out    = rgb3;

endmodule

`default_nettype wire

// File: tb/tb_draw_bg_rom_reader.sv
//------------------------------------------------------------------------------
// tb_draw_bg_rom_reader : directed vectors, expected results queued for a monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_draw_bg_rom_reader;

  localparam int X = -1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  draw_bg_rom_reader_if #(.ADDR_W(20)) ifa ();
  draw_bg_rom_reader_if #(.ADDR_W(12)) ifb ();

  draw_bg_rom_reader #(.IMG_W(1024), .IMG_H(768), .ADDR_W(20), .SCROLL_STEP(4),
                       .KEY_COLOR(12'hF0F))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  draw_bg_rom_reader #(.IMG_W(48), .IMG_H(64), .ADDR_W(12), .SCROLL_STEP(1),
                       .KEY_COLOR(12'hF0F))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    if (a == 20'd2050) return 12'hF0F;
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk) begin
    ifa.rom_rgb <= rom_fn(ifa.rom_addr);
    ifb.rom_rgb <= rom_fn({8'd0, ifb.rom_addr});
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          inst;
    logic [25:0] tm;
    logic        chk_rgb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int          due;
    int          inst;
    logic [19:0] addr;
  } addr_t;

  pix_t  pq[$];
  addr_t aq[$];
  int    checks = 0;
  int    errors = 0;

  logic [25:0] tm_a, tm_b;
  assign tm_a = {ifa.hcount_out, ifa.vcount_out, ifa.hsync_out, ifa.vsync_out,
                 ifa.hblnk_out, ifa.vblnk_out};
  assign tm_b = {ifb.hcount_out, ifb.vcount_out, ifb.hsync_out, ifb.vsync_out,
                 ifb.hblnk_out, ifb.vblnk_out};

  pix_t        pe;
  addr_t       ae;
  logic [25:0] act_tm;
  logic [11:0] act_rgb;
  logic [19:0] act_addr;

  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      pe      = pq.pop_front();
      act_tm  = (pe.inst == 0) ? tm_a : tm_b;
      act_rgb = (pe.inst == 0) ? ifa.rgb_out : ifb.rgb_out;
      checks++;
      if (pe.due != cyc || act_tm !== pe.tm) begin
        errors++;
        $display("FAIL timing inst%0d cyc%0d: got %h want %h", pe.inst, cyc, act_tm, pe.tm);
      end
      if (pe.chk_rgb) begin
        checks++;
        if (act_rgb !== pe.rgb) begin
          errors++;
          $display("FAIL rgb_out inst%0d cyc%0d: got %h want %h", pe.inst, cyc, act_rgb, pe.rgb);
        end
      end
    end
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ae       = aq.pop_front();
      act_addr = (ae.inst == 0) ? ifa.rom_addr : {8'd0, ifb.rom_addr};
      checks++;
      if (ae.due != cyc || act_addr !== ae.addr) begin
        errors++;
        $display("FAIL rom_addr inst%0d cyc%0d: got %0d want %0d", ae.inst, cyc, act_addr, ae.addr);
      end
    end
  end

  task automatic step(input logic [10:0] hc, input logic [10:0] vc, input logic hb,
                      input logic vb, input logic [11:0] rgb, input logic sen,
                      input int ea_rgb, input int eb_rgb, input int ea_addr, input int eb_addr);
    pix_t  e;
    addr_t a;
    @(negedge clk);
    ifa.hcount_in = hc;  ifb.hcount_in = hc;
    ifa.vcount_in = vc;  ifb.vcount_in = vc;
    ifa.hsync_in  = hc[1]; ifb.hsync_in = hc[1];
    ifa.vsync_in  = vc[1]; ifb.vsync_in = vc[1];
    ifa.hblnk_in  = hb;  ifb.hblnk_in = hb;
    ifa.vblnk_in  = vb;  ifb.vblnk_in = vb;
    ifa.rgb_in    = rgb; ifb.rgb_in   = rgb;
    ifa.scroll_en = sen; ifb.scroll_en = sen;
    e.due = cyc + 3;
    e.tm  = {hc, vc, hc[1], vc[1], hb, vb};
    e.inst = 0; e.chk_rgb = (ea_rgb >= 0); e.rgb = ea_rgb[11:0]; pq.push_back(e);
    e.inst = 1; e.chk_rgb = (eb_rgb >= 0); e.rgb = eb_rgb[11:0]; pq.push_back(e);
    a.due = cyc + 1;
    if (ea_addr >= 0) begin a.inst = 0; a.addr = ea_addr[19:0]; aq.push_back(a); end
    if (eb_addr >= 0) begin a.inst = 1; a.addr = eb_addr[19:0]; aq.push_back(a); end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_zero();
    chk("reset rgb_a", {20'd0, ifa.rgb_out}, 32'd0);
    chk("reset tm_a", {6'd0, tm_a}, 32'd0);
    chk("reset addr_a", {12'd0, ifa.rom_addr}, 32'd0);
    chk("reset rgb_b", {20'd0, ifb.rgb_out}, 32'd0);
    chk("reset tm_b", {6'd0, tm_b}, 32'd0);
    chk("reset addr_b", {20'd0, ifb.rom_addr}, 32'd0);
  endtask

  initial begin
    ifa.hcount_in = '0; ifa.vcount_in = '0; ifa.hsync_in = 0; ifa.vsync_in = 0;
    ifa.hblnk_in = 0; ifa.vblnk_in = 0; ifa.rgb_in = '0; ifa.scroll_en = 0;
    ifb.hcount_in = '0; ifb.vcount_in = '0; ifb.hsync_in = 0; ifb.vsync_in = 0;
    ifb.hblnk_in = 0; ifb.vblnk_in = 0; ifb.rgb_in = '0; ifb.scroll_en = 0;
    repeat (2) @(negedge clk);
    check_zero();
    rst_n = 1'b1;

    // window addressing, colour key, blanking and window edges
    step(5,    3,   0, 0, 12'h111, 0, 12'h9A0, 12'h530, 3077,   149);
    step(2,    2,   0, 0, 12'h0F0, 0, 12'h0F0, 12'h5C7, 2050,   98);
    step(6,    3,   0, 0, 12'h0F0, 0, 12'h9A3, 12'h533, 3078,   150);
    step(7,    3,   1, 0, 12'hABC, 0, 12'h000, 12'h000, 3078,   150);
    step(100,  3,   0, 0, 12'h123, 0, 12'h9C1, 12'h123, 3172,   150);
    step(47,   63,  0, 0, 12'h222, 0, 12'h98A, 12'hE5A, 64559,  3071);
    step(48,   63,  0, 0, 12'h333, 0, 12'h995, 12'h333, 64560,  3071);
    step(0,    64,  0, 0, 12'h444, 0, 12'h5A5, 12'h444, 65536,  3071);
    step(1023, 767, 0, 0, 12'h555, 0, 12'hA5A, 12'h555, 786431, 3071);
    step(1024, 767, 0, 0, 12'h666, 0, 12'h666, 12'h666, 786431, 3071);

    // scroll: three enabled vblank rises (one held high), one disabled rise
    step(0, 768, 0, 1, 12'h777, 1, 12'h000, X, X, X);
    step(0, 769, 0, 1, 12'h777, 1, 12'h000, X, X, X);
    step(0, 770, 0, 1, 12'h777, 1, X, X, X, X);
    step(0, 771, 0, 1, 12'h777, 1, X, X, X, X);
    step(0, 772, 0, 0, 12'h777, 1, X, X, X, X);
    step(0, 768, 0, 1, 12'h777, 1, X, X, X, X);
    step(0, 769, 0, 0, 12'h777, 1, X, X, X, X);
    step(0, 768, 0, 1, 12'h777, 1, X, X, X, X);
    step(0, 769, 0, 0, 12'h777, 0, X, X, X, X);
    step(0, 768, 0, 1, 12'h777, 0, X, X, X, X);
    step(0, 769, 0, 0, 12'h777, 0, X, X, X, X);
    step(1020, 0, 0, 0, 12'h777, 0, 12'h5AD, X, 8,    X);
    step(3,    1, 0, 0, 12'h777, 0, 12'h1AA, X, 1039, X);
    step(1011, 0, 0, 0, 12'h777, 0, 12'h65A, X, 1023, X);
    step(1012, 0, 0, 0, 12'h777, 0, 12'h5A5, X, 0,    X);

    // reset mid-stream while the pipeline holds non-zero data
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1020, 0, 0, 0, 12'h777, 0, 12'h659, 12'h777, 1020, 0);

    repeat (6) @(negedge clk);
    checks++;
    if (pq.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", pq.size() + aq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
